// File: rtl/fp_normalizer.sv
// fp_normalizer: renormalize, round and pack the adder's extended mantissa into binary32.
// Optional macro FP_NORM_ROUND_EN adds the round-to-nearest-even state; without it results truncate.
module fp_normalizer #(
    parameter int NORM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis,
    input  logic        loss,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        inexact,
    output logic        overflow
);

`ifdef FP_NORM_ROUND_EN
    typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
    localparam state_t AFTER_NORM = ROUND;
`else
    typedef enum logic [2:0] {IDLE, NORM, PACK, DONE} state_t;
    localparam state_t AFTER_NORM = PACK;
`endif

    state_t      state;
    logic        sgn_q;
    logic [27:0] man_q;
    logic        sticky_q;
    logic [8:0]  exp_q;
    logic        zero_q;
    logic        special_q;
    logic [4:0]  lz;
    logic [8:0]  step;
    logic        guard;
    logic        tail;

    assign in_ready = (state == IDLE);
    assign guard    = man_q[2];
    assign tail     = man_q[1] | man_q[0] | sticky_q;

    // Distance from the leading one (below bit 26) up to the hidden-bit position.
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (man_q[i]) lz = 5'(26 - i);
        end
    end

    // Shift at most NORM_STEP per cycle and never take the exponent below 1.
    always_comb begin
        step = {4'd0, lz};
        if (step > 9'(NORM_STEP)) step = 9'(NORM_STEP);
        if (step > exp_q - 9'd1)  step = exp_q - 9'd1;
    end

`ifdef FP_NORM_ROUND_EN
    logic        round_up;
    logic [27:0] man_inc;
    logic        rnd_inexact_q;

    assign round_up = guard & (tail | man_q[3]);
    assign man_inc  = man_q + 28'd8;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sgn_q     <= 1'b0;
            man_q     <= 28'd0;
            sticky_q  <= 1'b0;
            exp_q     <= 9'd0;
            zero_q    <= 1'b0;
            special_q <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'd0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
`ifdef FP_NORM_ROUND_EN
            rnd_inexact_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn_q     <= sign;
                        man_q     <= mantis;
                        sticky_q  <= loss;
                        exp_q     <= (exp == 8'd0) ? 9'd1 : {1'b0, exp};
                        zero_q    <= 1'b0;
                        special_q <= (exp == 8'hFF);
                        state     <= (exp == 8'hFF) ? PACK : NORM;
                    end
                end
                NORM: begin
                    if (man_q == 28'd0) begin
                        zero_q <= 1'b1;
                        state  <= PACK;
                    end else if (man_q[27]) begin
                        man_q    <= man_q >> 1;
                        sticky_q <= sticky_q | man_q[0];
                        exp_q    <= exp_q + 9'd1;
                        state    <= AFTER_NORM;
                    end else if (man_q[26] || exp_q == 9'd1) begin
                        state <= AFTER_NORM;
                    end else begin
                        man_q <= man_q << step;
                        exp_q <= exp_q - step;
                        // A step that lands the leading one on bit 26 finishes normalization.
                        if (step == {4'd0, lz}) state <= AFTER_NORM;
                    end
                end
`ifdef FP_NORM_ROUND_EN
                ROUND: begin
                    rnd_inexact_q <= guard | tail;
                    if (round_up) begin
                        if (man_inc[27]) begin
                            man_q <= man_inc >> 1;
                            exp_q <= exp_q + 9'd1;
                        end else begin
                            man_q <= man_inc;
                        end
                    end
                    state <= PACK;
                end
`endif
                PACK: begin
                    overflow <= 1'b0;
                    if (special_q) begin
                        result  <= (man_q[25:3] != 23'd0) ? 32'h7FC0_0000 : {sgn_q, 8'hFF, 23'd0};
                        inexact <= 1'b0;
                    end else if (zero_q) begin
                        result  <= {sgn_q, 31'd0};
                        inexact <= 1'b0;
                    end else if (exp_q >= 9'd255) begin
                        result   <= {sgn_q, 8'hFF, 23'd0};
                        inexact  <= 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        if (exp_q == 9'd1 && !man_q[26]) begin
                            result <= {sgn_q, 8'd0, man_q[25:3]};
                        end else begin
                            result <= {sgn_q, exp_q[7:0], man_q[25:3]};
                        end
`ifdef FP_NORM_ROUND_EN
                        inexact <= rnd_inexact_q;
`else
                        inexact <= guard | tail;
`endif
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: expectations queued at drive time, popped when out_valid rises.
module tb_fp_normalizer;
    localparam int NORM_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign = 1'b0;
    logic [7:0]  exp = 8'd0;
    logic [27:0] mantis = 28'd0;
    logic        loss = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        inexact;
    logic        overflow;

    typedef struct {
        logic [31:0] result;
        logic        inexact;
        logic        overflow;
        int          lat;
    } expect_t;

    expect_t sb[$];
    int checks = 0;
    int errors = 0;

    fp_normalizer #(.NORM_STEP(NORM_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp       (exp),
        .mantis    (mantis),
        .loss      (loss),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .inexact   (inexact),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Reference model: computes result, flags and acceptance-to-valid latency (0 = not checked).
    function automatic expect_t model(input logic s, input logic [7:0] e_in, input logic [27:0] m_in, input logic l);
        expect_t x;
        int e;
        int k;
        int d;
        int n;
        logic [27:0] m;
        logic st;
        logic g;
        logic t;
        x.overflow = 1'b0;
        x.inexact  = 1'b0;
        x.lat      = 0;
        if (e_in == 8'hFF) begin
            x.result = (m_in[25:3] != 23'd0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
            x.lat    = 1;
            return x;
        end
        if (m_in == 28'd0) begin
            x.result = {s, 31'd0};
            return x;
        end
        e  = (e_in == 8'd0) ? 1 : int'(e_in);
        m  = m_in;
        st = l;
        n  = 1;
        if (m[27]) begin
            st = st | m[0];
            m  = m >> 1;
            e  = e + 1;
        end else if (!m[26]) begin
            k = 0;
            for (int i = 25; i >= 0; i--) begin
                if (m[i]) begin
                    k = i;
                    break;
                end
            end
            d = 26 - k;
            if (d <= e - 1) begin
                m = m << d;
                e = e - d;
                n = (d + NORM_STEP - 1) / NORM_STEP;
            end else begin
                n = (e - 1 + NORM_STEP - 1) / NORM_STEP + 1;
                m = m << (e - 1);
                e = 1;
            end
        end
        g = m[2];
        t = m[1] | m[0] | st;
        x.inexact = g | t;
`ifdef FP_NORM_ROUND_EN
        if (g & (t | m[3])) begin
            m = m + 28'd8;
            if (m[27]) begin
                m = m >> 1;
                e = e + 1;
            end
        end
        x.lat = n + 2;
`else
        x.lat = n + 1;
`endif
        if (e >= 255) begin
            x.result   = {s, 8'hFF, 23'd0};
            x.overflow = 1'b1;
            x.inexact  = 1'b1;
        end else if (e == 1 && !m[26]) begin
            x.result = {s, 8'd0, m[25:3]};
        end else begin
            x.result = {s, 8'(e), m[25:3]};
        end
        return x;
    endfunction

    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] m, input logic l);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        sign     = s;
        exp      = e;
        mantis   = m;
        loss     = l;
        sb.push_back(model(s, e, m, l));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("in_ready_drop", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic collectResult(input int hold_cycles);
        int n = 0;
        expect_t x;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("result", result, x.result);
        checkOutput("inexact", {31'd0, inexact}, {31'd0, x.inexact});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, x.overflow});
        if (x.lat > 0) checkOutput("latency", n, x.lat);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_result", result, x.result);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("accept_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("accept_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [27:0] rm;
        // in_valid held high during reset must be ignored.
        in_valid = 1'b1;
        exp      = 8'd127;
        mantis   = 28'h4000000;
        #12;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_flags", {30'd0, inexact, overflow}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", {30'd0, in_ready, out_valid}, 32'd2);

        applyStimulus(1'b0, 8'd127, 28'h4000000, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd127, 28'h8000000, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd130, 28'h0000400, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd127, 28'h400000C, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd127, 28'h4000004, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd127, 28'h4000004, 1'b1); collectResult(0);
        applyStimulus(1'b0, 8'd254, 28'h8000000, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd255, 28'h4000008, 1'b0); collectResult(0);
        applyStimulus(1'b1, 8'd255, 28'h4000000, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd3,   28'h0000400, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd0,   28'h2000000, 1'b0); collectResult(0);
        applyStimulus(1'b0, 8'd127, 28'h7FFFFFC, 1'b0); collectResult(0);
        applyStimulus(1'b1, 8'd100, 28'h0000000, 1'b1); collectResult(5);

        // Reset mid-normalization aborts the operation without producing a result.
        applyStimulus(1'b0, 8'd130, 28'h0000400, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd127, 28'h8000000, 1'b0); collectResult(0);

        for (int i = 0; i < 24; i++) begin
            rm = 28'($urandom) >> $urandom_range(0, 27);
            applyStimulus(1'($urandom), 8'($urandom_range(0, 254)), rm, 1'($urandom));
            collectResult(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
